// File: rtl/fsm_state_monitor_if.sv
// Bus between an observed FSM's state output and the runtime state monitor.
// The producer side drives the sampled state code plus a clear request; the
// monitor side returns coverage, counters and latched error information.
interface fsm_state_monitor_if #(
    parameter int STATE_W  = 2,
    parameter int N_STATES = 3,
    parameter int CNT_W    = 8
);
    logic                clr;
    logic                state_valid;
    logic [STATE_W-1:0]  state_in;
    logic [N_STATES-1:0] visited;
    logic                coverage_done;
    logic [CNT_W-1:0]    trans_cnt;
    logic                stall;
    logic                err_trans;
    logic                err_code;
    logic [STATE_W-1:0]  err_from;
    logic [STATE_W-1:0]  err_to;
    logic [1:0]          mon_state;

    modport master (
        output clr, state_valid, state_in,
        input  visited, coverage_done, trans_cnt, stall,
        input  err_trans, err_code, err_from, err_to, mon_state
    );

    modport slave (
        input  clr, state_valid, state_in,
        output visited, coverage_done, trans_cnt, stall,
        output err_trans, err_code, err_from, err_to, mon_state
    );
endinterface

// File: rtl/fsm_state_monitor.sv
// Runtime checker for an FSM state bus: legal-transition map, visited-state
// coverage, saturating transition count, stall detection, first-error capture.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no valid sample since reset/clear; next valid sample is the first
// TRACK  | following the observed FSM, no error seen yet
// FAULT  | error latched; tracking continues, error capture is frozen
module fsm_state_monitor #(
    parameter int                               STATE_W     = 2,
    parameter int                               N_STATES    = 3,
    parameter logic [N_STATES*N_STATES-1:0]     LEGAL_MAP   = 9'h04A,
    parameter int                               STALL_LIMIT = 8,
    parameter int                               CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    fsm_state_monitor_if.slave  mon_if
);

    localparam int MAP_W = N_STATES * N_STATES;
    localparam int IDX_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int SC_W  = $clog2(STALL_LIMIT + 1);

    // One extra bit so N_STATES == 2**STATE_W is still representable.
    localparam logic [STATE_W:0] N_ST     = N_STATES[STATE_W:0];
    localparam logic [SC_W-1:0]  SC_LIMIT = STALL_LIMIT[SC_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } mon_state_e;

    mon_state_e          state_q, state_d;
    logic [STATE_W-1:0]  prev_q, prev_d;
    logic [SC_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic                stall_q, stall_d;
    logic [N_STATES-1:0] visited_q, visited_d;
    logic                cov_q, cov_d;
    logic [CNT_W-1:0]    trans_cnt_q, trans_cnt_d;
    logic                err_trans_q, err_trans_d;
    logic                err_code_q, err_code_d;
    logic [STATE_W-1:0]  err_from_q, err_from_d;
    logic [STATE_W-1:0]  err_to_q, err_to_d;

    logic [STATE_W-1:0]  cur;
    logic                cur_bad;
    logic [IDX_W-1:0]    map_idx;
    logic                is_legal;

    // Next-state and tracking logic; only a valid sample changes anything.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        stall_cnt_d = stall_cnt_q;
        stall_d     = stall_q;
        visited_d   = visited_q;
        trans_cnt_d = trans_cnt_q;
        err_trans_d = err_trans_q;
        err_code_d  = err_code_q;
        err_from_d  = err_from_q;
        err_to_d    = err_to_q;

        cur      = mon_if.state_in;
        cur_bad  = ({1'b0, cur} >= N_ST);
        map_idx  = IDX_W'(prev_q) * IDX_W'(N_STATES) + IDX_W'(cur);
        is_legal = LEGAL_MAP[map_idx];

        if (mon_if.state_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (cur_bad) begin
                        err_code_d = 1'b1;
                        err_from_d = '0;
                        err_to_d   = cur;
                        state_d    = S_FAULT;
                    end else begin
                        prev_d         = cur;
                        visited_d[cur] = 1'b1;
                        state_d        = S_TRACK;
                    end
                end
                S_TRACK, S_FAULT: begin
                    if (cur_bad) begin
                        // Bad codes never update prev or visited.
                        if (state_q == S_TRACK) begin
                            err_code_d = 1'b1;
                            err_from_d = prev_q;
                            err_to_d   = cur;
                        end
                        state_d = S_FAULT;
                    end else if (cur == prev_q) begin
                        if (stall_cnt_q < SC_LIMIT) begin
                            stall_cnt_d = stall_cnt_q + SC_W'(1);
                        end
                        stall_d = (stall_cnt_q >= (SC_LIMIT - SC_W'(1)));
                    end else begin
                        visited_d[cur] = 1'b1;
                        prev_d         = cur;
                        stall_cnt_d    = '0;
                        stall_d        = 1'b0;
                        if (is_legal) begin
                            if (trans_cnt_q != CNT_MAX) begin
                                trans_cnt_d = trans_cnt_q + CNT_W'(1);
                            end
                        end else begin
                            if (state_q == S_TRACK) begin
                                err_trans_d = 1'b1;
                                err_from_d  = prev_q;
                                err_to_d    = cur;
                            end
                            state_d = S_FAULT;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        cov_d = &visited_d;
    end

    // State registers; rst and clr both clear everything, a same-cycle sample is dropped.
    always_ff @(posedge clk) begin
        if (rst || mon_if.clr) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
            visited_q   <= '0;
            cov_q       <= 1'b0;
            trans_cnt_q <= '0;
            err_trans_q <= 1'b0;
            err_code_q  <= 1'b0;
            err_from_q  <= '0;
            err_to_q    <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
            visited_q   <= visited_d;
            cov_q       <= cov_d;
            trans_cnt_q <= trans_cnt_d;
            err_trans_q <= err_trans_d;
            err_code_q  <= err_code_d;
            err_from_q  <= err_from_d;
            err_to_q    <= err_to_d;
        end
    end

    assign mon_if.visited       = visited_q;
    assign mon_if.coverage_done = cov_q;
    assign mon_if.trans_cnt     = trans_cnt_q;
    assign mon_if.stall         = stall_q;
    assign mon_if.err_trans     = err_trans_q;
    assign mon_if.err_code      = err_code_q;
    assign mon_if.err_from      = err_from_q;
    assign mon_if.err_to        = err_to_q;
    assign mon_if.mon_state     = state_q;

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Bench for fsm_state_monitor: a behavioural reference model predicts the
// outputs for every driven cycle and queues them; scenario tasks pop the
// prediction and compare it against the registered outputs.
module tb_fsm_state_monitor;

    typedef struct packed {
        logic [2:0] visited;
        logic       cov;
        logic [7:0] trans_cnt;
        logic       stall;
        logic       err_trans;
        logic       err_code;
        logic [1:0] err_from;
        logic [1:0] err_to;
        logic [1:0] mon_state;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    fsm_state_monitor_if #(.STATE_W(2), .N_STATES(3), .CNT_W(8)) bus ();
    fsm_state_monitor_if #(.STATE_W(2), .N_STATES(3), .CNT_W(2)) bus2 ();

    fsm_state_monitor #(.STATE_W(2), .N_STATES(3), .LEGAL_MAP(9'h04A),
                        .STALL_LIMIT(8), .CNT_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .mon_if (bus)
    );

    fsm_state_monitor #(.STATE_W(2), .N_STATES(3), .LEGAL_MAP(9'h04A),
                        .STALL_LIMIT(8), .CNT_W(2)) dut2 (
        .clk    (clk),
        .rst    (rst2),
        .mon_if (bus2)
    );

    int checks = 0;
    int passed = 0;

    exp_t sb[$];
    int   sb2[$];

    // Reference model state
    int         m_mon, m_prev, m_scnt, m_cnt;
    logic       m_stall, m_et, m_ec;
    logic [2:0] m_vis;
    logic [1:0] m_ef, m_eto;
    logic [8:0] lmap = 9'h04A;
    int         m2_changes, m2_prev;
    logic       m2_started;

    function automatic exp_t observe();
        exp_t o;
        o.visited   = bus.visited;
        o.cov       = bus.coverage_done;
        o.trans_cnt = bus.trans_cnt;
        o.stall     = bus.stall;
        o.err_trans = bus.err_trans;
        o.err_code  = bus.err_code;
        o.err_from  = bus.err_from;
        o.err_to    = bus.err_to;
        o.mon_state = bus.mon_state;
        return o;
    endfunction

    task automatic model(input logic r, input logic c, input logic v, input logic [1:0] code);
        exp_t e;
        int   ci;
        ci = int'(code);
        if (r || c) begin
            m_mon = 0; m_prev = 0; m_scnt = 0; m_cnt = 0;
            m_stall = 0; m_et = 0; m_ec = 0; m_vis = '0; m_ef = '0; m_eto = '0;
        end else if (v) begin
            if (m_mon == 0) begin
                if (ci >= 3) begin
                    m_ec = 1; m_ef = 2'd0; m_eto = code; m_mon = 2;
                end else begin
                    m_prev = ci; m_vis[ci] = 1'b1; m_mon = 1;
                end
            end else if (ci >= 3) begin
                if (m_mon == 1) begin
                    m_ec = 1; m_ef = 2'(m_prev); m_eto = code;
                end
                m_mon = 2;
            end else if (ci == m_prev) begin
                if (m_scnt < 8) m_scnt++;
                m_stall = (m_scnt >= 8);
            end else begin
                if (lmap[m_prev*3 + ci]) begin
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    if (m_mon == 1) begin
                        m_et = 1; m_ef = 2'(m_prev); m_eto = code;
                    end
                    m_mon = 2;
                end
                m_vis[ci] = 1'b1;
                m_prev = ci; m_scnt = 0; m_stall = 0;
            end
        end
        e.visited   = m_vis;
        e.cov       = &m_vis;
        e.trans_cnt = 8'(m_cnt);
        e.stall     = m_stall;
        e.err_trans = m_et;
        e.err_code  = m_ec;
        e.err_from  = m_ef;
        e.err_to    = m_eto;
        e.mon_state = 2'(m_mon);
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic c, input logic v, input logic [1:0] code);
        rst = r; bus.clr = c; bus.state_valid = v; bus.state_in = code;
        model(r, c, v, code);
        @(posedge clk);
        #1;
        rst = 1'b0; bus.clr = 1'b0; bus.state_valid = 1'b0;
    endtask

    // Scoreboard pop: the outputs now visible belong to the last driven cycle.
    function automatic exp_t pop_latest();
        exp_t e;
        e = sb.pop_back();
        sb.delete();
        return e;
    endfunction

    task automatic test_reset();
        exp_t e, o;
        drive(1, 0, 1, 2'd2);
        e = pop_latest(); o = observe();
        checks++;
        if (o !== e) $display("FAIL reset_all: got %h expected %h", o, e);
        else passed++;
        checks++;
        if (o !== '0) $display("FAIL reset_zero: got %h expected 0", o);
        else passed++;
    endtask

    task automatic test_legal_walk();
        exp_t e, o;
        drive(0, 0, 1, 2'd0);
        drive(0, 0, 1, 2'd1);
        drive(0, 0, 1, 2'd0);
        drive(0, 0, 1, 2'd1);
        e = pop_latest(); o = observe();
        checks++;
        if (o !== e) $display("FAIL walk_model: got %h expected %h", o, e);
        else passed++;
        checks++;
        if (o.trans_cnt !== 8'd3 || o.visited !== 3'b011 || o.cov !== 1'b0 ||
            o.err_trans !== 1'b0 || o.err_code !== 1'b0 || o.mon_state !== 2'd1)
            $display("FAIL walk_values: got %h expected cnt=3 vis=011 cov=0 noerr mon=1", o);
        else passed++;
    endtask

    task automatic test_illegal_trans();
        exp_t e, o;
        drive(0, 0, 1, 2'd0);
        drive(0, 0, 1, 2'd2);
        e = pop_latest(); o = observe();
        checks++;
        if (o !== e) $display("FAIL illegal_model: got %h expected %h", o, e);
        else passed++;
        checks++;
        if (o.err_trans !== 1'b1 || o.err_from !== 2'd0 || o.err_to !== 2'd2 ||
            o.visited !== 3'b111 || o.cov !== 1'b1 || o.mon_state !== 2'd2)
            $display("FAIL illegal_values: got %h expected errT=1 from=0 to=2 vis=111 cov=1 mon=2", o);
        else passed++;
        drive(0, 0, 1, 2'd1);
        e = pop_latest(); o = observe();
        checks++;
        if (o.err_from !== 2'd0 || o.err_to !== 2'd2 || o !== e)
            $display("FAIL illegal_frozen: got %h expected %h", o, e);
        else passed++;
    endtask

    task automatic test_bad_code();
        exp_t e, o;
        drive(1, 0, 0, 2'd0);
        drive(0, 0, 1, 2'd3);
        e = pop_latest(); o = observe();
        checks++;
        if (o !== e) $display("FAIL badcode_model: got %h expected %h", o, e);
        else passed++;
        checks++;
        if (o.err_code !== 1'b1 || o.err_to !== 2'd3 || o.err_from !== 2'd0 ||
            o.visited !== 3'b000 || o.mon_state !== 2'd2)
            $display("FAIL badcode_values: got %h expected errC=1 from=0 to=3 vis=0 mon=2", o);
        else passed++;
    endtask

    task automatic test_stall();
        exp_t e, o;
        drive(1, 0, 0, 2'd0);
        drive(0, 0, 1, 2'd0);
        drive(0, 0, 1, 2'd1);
        void'(pop_latest());
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 1, 2'd1);
            drive(0, 0, 0, 2'd0);
            e = pop_latest(); o = observe();
            if (i == 7) begin
                checks++;
                if (o.stall !== 1'b0 || o !== e)
                    $display("FAIL stall_early: got %h expected %h", o, e);
                else passed++;
            end
            if (i == 8) begin
                checks++;
                if (o.stall !== 1'b1 || o !== e)
                    $display("FAIL stall_raise: got %h expected %h", o, e);
                else passed++;
            end
        end
        drive(0, 0, 1, 2'd0);
        e = pop_latest(); o = observe();
        checks++;
        if (o.stall !== 1'b0 || o.trans_cnt !== 8'd2 || o !== e)
            $display("FAIL stall_clear: got %h expected %h", o, e);
        else passed++;
    endtask

    task automatic test_rst_priority();
        exp_t e, o;
        drive(0, 0, 1, 2'd1);
        drive(1, 1, 1, 2'd2);
        e = pop_latest(); o = observe();
        checks++;
        if (o !== '0 || o !== e) $display("FAIL rst_mid_track: got %h expected 0", o);
        else passed++;
        drive(0, 0, 1, 2'd1);
        e = pop_latest(); o = observe();
        checks++;
        if (o.visited !== 3'b010 || o.trans_cnt !== 8'd0 || o.mon_state !== 2'd1 || o !== e)
            $display("FAIL rst_first_sample: got %h expected %h", o, e);
        else passed++;
        drive(0, 1, 1, 2'd2);
        e = pop_latest(); o = observe();
        checks++;
        if (o !== '0 || o !== e) $display("FAIL clr_with_sample: got %h expected 0", o);
        else passed++;
    endtask

    task automatic drive2(input logic r, input logic v, input logic [1:0] code);
        rst2 = r; bus2.clr = 1'b0; bus2.state_valid = v; bus2.state_in = code;
        if (r) begin
            m2_changes = 0; m2_started = 0;
        end else if (v) begin
            if (m2_started && int'(code) != m2_prev) m2_changes++;
            m2_started = 1; m2_prev = int'(code);
        end
        sb2.push_back((m2_changes > 3) ? 3 : m2_changes);
        @(posedge clk);
        #1;
        rst2 = 1'b0; bus2.state_valid = 1'b0;
    endtask

    task automatic test_saturation();
        int exp_cnt;
        drive2(1, 0, 2'd0);
        void'(sb2.pop_front());
        drive2(0, 1, 2'd0);
        void'(sb2.pop_front());
        for (int i = 0; i < 6; i++) begin
            drive2(0, 1, (i % 2 == 0) ? 2'd1 : 2'd0);
            exp_cnt = sb2.pop_front();
            checks++;
            if (int'(bus2.trans_cnt) !== exp_cnt)
                $display("FAIL sat_cnt_%0d: got %0d expected %0d", i, bus2.trans_cnt, exp_cnt);
            else passed++;
        end
        checks++;
        if (bus2.trans_cnt !== 2'd3 || bus2.err_trans !== 1'b0)
            $display("FAIL sat_final: got cnt=%0d errT=%0b expected cnt=3 errT=0",
                     bus2.trans_cnt, bus2.err_trans);
        else passed++;
    endtask

    initial begin
        bus.clr = 1'b0; bus.state_valid = 1'b0; bus.state_in = '0;
        bus2.clr = 1'b0; bus2.state_valid = 1'b0; bus2.state_in = '0;
        m2_changes = 0; m2_prev = 0; m2_started = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_legal_walk();
        test_illegal_trans();
        test_bad_code();
        test_stall();
        test_rst_priority();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
